// File: rtl/uart_rx_os16.sv
// uart_rx_os16: single-clock UART receiver with 16x oversampling.
//
// Receives start, 5-8 data bits LSB-first, optional parity and 1 or 2 stop bits.
// A divider on clk produces the 16x oversample tick. rx goes through a 2-flop
// synchronizer. Each bit is the majority of three samples taken at phases 7, 8 and 9.
// Every frame is delivered on a valid/ready handshake with parity and framing
// error flags.
//
// Ports:
//   clk, rst     system clock, asynchronous active-high reset
//   rx           serial line, idle high, asynchronous to clk
//   baud_div     clk cycles per oversample tick minus 1
//   length       data bits 5..8 (other values mean 8)
//   parity_en    parity bit present
//   parity_type  1: parity bit = ^data, 0: parity bit = ~^data
//   stop2        two stop bits checked
//   rx_data      received data, right-aligned
//   rx_valid     rx_data/parity_err/frame_err valid, held until rx_ready
//   rx_ready     consumer accept
//   parity_err   parity mismatch for the held frame
//   frame_err    a checked stop bit was sampled 0 for the held frame
//   overrun      1-cycle pulse: a frame completed while the previous one was unaccepted
//   busy         receiver not idle
module uart_rx_os16 #(
  parameter int unsigned DIV_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             rx,
  input  logic [DIV_W-1:0] baud_div,
  input  logic [3:0]       length,
  input  logic             parity_en,
  input  logic             parity_type,
  input  logic             stop2,
  output logic [7:0]       rx_data,
  output logic             rx_valid,
  input  logic             rx_ready,
  output logic             parity_err,
  output logic             frame_err,
  output logic             overrun,
  output logic             busy
);

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
    StParity,
    StStop1,
    StStop2
  } state_e;

  state_e           state_q, state_d;
  logic             rx_meta_q, rxs_q;
  logic [DIV_W-1:0] tick_cnt_q, tick_cnt_d;
  logic [3:0]       phase_q, phase_d;
  logic [2:0]       bit_idx_q, bit_idx_d;
  logic [1:0]       samp_q, samp_d;
  logic [7:0]       shift_q, shift_d;
  logic             perr_q, perr_d;
  logic             ferr_q, ferr_d;
  logic             fin_q, fin_d;

  // Frame configuration captured at start detection.
  logic [DIV_W-1:0] div_q, div_d;
  logic [2:0]       len_m1_q, len_m1_d;
  logic             par_en_q, par_en_d;
  logic             par_type_q, par_type_d;
  logic             stop2_q, stop2_d;

  logic       tick;
  logic       maj;
  logic       exp_par;
  logic [2:0] len_m1_sel;

  assign tick    = (state_q != StIdle) && (tick_cnt_q == div_q);
  // Majority of the samples at phases 7 and 8 and the live sample at phase 9.
  assign maj     = (samp_q[0] & samp_q[1]) | (samp_q[0] & rxs_q) | (samp_q[1] & rxs_q);
  // Bits of shift_q above the frame length are zero, so they do not affect parity.
  assign exp_par = par_type_q ? ^shift_q : ~^shift_q;
  assign busy    = (state_q != StIdle);

  always_comb begin
    len_m1_sel = 3'd7;
    case (length)
      4'd5:    len_m1_sel = 3'd4;
      4'd6:    len_m1_sel = 3'd5;
      4'd7:    len_m1_sel = 3'd6;
      default: len_m1_sel = 3'd7;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    tick_cnt_d = tick_cnt_q;
    phase_d    = phase_q;
    bit_idx_d  = bit_idx_q;
    samp_d     = samp_q;
    shift_d    = shift_q;
    perr_d     = perr_q;
    ferr_d     = ferr_q;
    fin_d      = 1'b0;
    div_d      = div_q;
    len_m1_d   = len_m1_q;
    par_en_d   = par_en_q;
    par_type_d = par_type_q;
    stop2_d    = stop2_q;

    if (state_q != StIdle) begin
      tick_cnt_d = tick ? '0 : tick_cnt_q + 1'b1;
      if (tick) begin
        phase_d = phase_q + 4'd1;
        if (phase_q == 4'd7) samp_d[0] = rxs_q;
        if (phase_q == 4'd8) samp_d[1] = rxs_q;
      end
    end

    case (state_q)
      StIdle: begin
        if (!rxs_q) begin
          state_d    = StStart;
          tick_cnt_d = '0;
          phase_d    = 4'd0;
          shift_d    = 8'h00;
          perr_d     = 1'b0;
          ferr_d     = 1'b0;
          div_d      = baud_div;
          len_m1_d   = len_m1_sel;
          par_en_d   = parity_en;
          par_type_d = parity_type;
          stop2_d    = stop2;
        end
      end
      StStart: begin
        if (tick && phase_q == 4'd9 && maj) begin
          state_d = StIdle;  // start bit did not hold: glitch
        end else if (tick && phase_q == 4'd15) begin
          state_d   = StData;
          bit_idx_d = 3'd0;
        end
      end
      StData: begin
        if (tick && phase_q == 4'd9) shift_d[bit_idx_q] = maj;
        if (tick && phase_q == 4'd15) begin
          if (bit_idx_q == len_m1_q) begin
            state_d = par_en_q ? StParity : StStop1;
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
          end
        end
      end
      StParity: begin
        if (tick && phase_q == 4'd9) perr_d = (maj != exp_par);
        if (tick && phase_q == 4'd15) state_d = StStop1;
      end
      StStop1: begin
        if (tick && phase_q == 4'd9) begin
          ferr_d = ferr_q | ~maj;
          if (!stop2_q) begin
            // Finish mid stop bit so a back-to-back start edge is not missed.
            state_d = StIdle;
            fin_d   = 1'b1;
          end
        end else if (tick && phase_q == 4'd15 && stop2_q) begin
          state_d = StStop2;
        end
      end
      StStop2: begin
        if (tick && phase_q == 4'd9) begin
          ferr_d  = ferr_q | ~maj;
          state_d = StIdle;
          fin_d   = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_meta_q  <= 1'b1;
      rxs_q      <= 1'b1;
      state_q    <= StIdle;
      tick_cnt_q <= '0;
      phase_q    <= 4'd0;
      bit_idx_q  <= 3'd0;
      samp_q     <= 2'b00;
      shift_q    <= 8'h00;
      perr_q     <= 1'b0;
      ferr_q     <= 1'b0;
      fin_q      <= 1'b0;
      div_q      <= '0;
      len_m1_q   <= 3'd0;
      par_en_q   <= 1'b0;
      par_type_q <= 1'b0;
      stop2_q    <= 1'b0;
      rx_data    <= 8'h00;
      rx_valid   <= 1'b0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      rx_meta_q  <= rx;
      rxs_q      <= rx_meta_q;
      state_q    <= state_d;
      tick_cnt_q <= tick_cnt_d;
      phase_q    <= phase_d;
      bit_idx_q  <= bit_idx_d;
      samp_q     <= samp_d;
      shift_q    <= shift_d;
      perr_q     <= perr_d;
      ferr_q     <= ferr_d;
      fin_q      <= fin_d;
      div_q      <= div_d;
      len_m1_q   <= len_m1_d;
      par_en_q   <= par_en_d;
      par_type_q <= par_type_d;
      stop2_q    <= stop2_d;

      overrun <= 1'b0;
      if (fin_q) begin
        // A frame loads if the holding register is empty or being emptied this cycle.
        if (!rx_valid || rx_ready) begin
          rx_data    <= shift_q;
          parity_err <= perr_q;
          frame_err  <= ferr_q;
          rx_valid   <= 1'b1;
        end else begin
          overrun <= 1'b1;
        end
      end else if (rx_valid && rx_ready) begin
        rx_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_os16.sv
module tb_uart_rx_os16;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        rx = 1'b1;
  logic [15:0] baud_div = 16'd3;
  logic [3:0]  length = 4'd8;
  logic        parity_en = 1'b0;
  logic        parity_type = 1'b0;
  logic        stop2 = 1'b0;
  logic        rx_ready = 1'b1;
  logic [7:0]  rx_data;
  logic        rx_valid, parity_err, frame_err, overrun, busy;

  uart_rx_os16 #(.DIV_W(16)) dut (
    .clk        (clk),
    .rst        (rst),
    .rx         (rx),
    .baud_div   (baud_div),
    .length     (length),
    .parity_en  (parity_en),
    .parity_type(parity_type),
    .stop2      (stop2),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .rx_ready   (rx_ready),
    .parity_err (parity_err),
    .frame_err  (frame_err),
    .overrun    (overrun),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0] d;
    logic       p;
    logic       f;
  } frm_t;

  typedef struct {
    logic [7:0] data;
    logic [3:0] len;
    logic       pe;
    logic       pt;
    logic       s2;
    logic       bad_par;
    logic [1:0] bad_stop;
    logic [7:0] exp_data;
    logic       exp_perr;
    logic       exp_ferr;
  } vec_t;

  frm_t got[$];
  int   n_cmp = 0;
  int   n_err = 0;
  int   ovr_cnt = 0;

  // Capture every accepted frame and every overrun pulse.
  always @(negedge clk) begin
    if (!rst) begin
      if (rx_valid && rx_ready) got.push_back({rx_data, parity_err, frame_err});
      if (overrun) ovr_cnt++;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic drive_bit(input logic v, input int clks);
    rx = v;
    repeat (clks) @(posedge clk);
    #1;
  endtask

  function automatic int eff_len(input logic [3:0] len);
    return (len >= 4'd5 && len <= 4'd8) ? int'(len) : 8;
  endfunction

  // Expected frame from the line-format rules: data masked to its length,
  // parity error only if a parity bit was sent wrong, framing error if any
  // checked stop bit was sent low.
  function automatic frm_t ref_frame(input logic [7:0] d, input logic [3:0] len, input logic pe,
                                     input logic s2, input logic bad_par,
                                     input logic [1:0] bad_stop);
    frm_t r;
    r.d = d & 8'((1 << eff_len(len)) - 1);
    r.p = pe & bad_par;
    r.f = bad_stop[0] | (s2 & bad_stop[1]);
    return r;
  endfunction

  task automatic send_frame(input logic [7:0] d, input logic [3:0] len, input logic pe,
                            input logic pt, input logic s2, input logic bad_par,
                            input logic [1:0] bad_stop, input int div);
    int n;
    int bclk;
    logic [7:0] m;
    logic p;
    n = eff_len(len);
    m = d & 8'((1 << n) - 1);
    p = (pt ? ^m : ~^m) ^ bad_par;
    bclk = 16 * (div + 1);
    @(posedge clk);
    #1;
    baud_div = 16'(div);
    length = len;
    parity_en = pe;
    parity_type = pt;
    stop2 = s2;
    drive_bit(1'b0, bclk);
    // Configuration is latched at start detection; disturb it mid-frame.
    baud_div = 16'($urandom);
    length = 4'($urandom);
    parity_en = 1'($urandom);
    parity_type = 1'($urandom);
    stop2 = 1'($urandom);
    for (int i = 0; i < n; i++) drive_bit(m[i], bclk);
    baud_div = 16'(div);
    length = len;
    parity_en = pe;
    parity_type = pt;
    stop2 = s2;
    if (pe) drive_bit(p, bclk);
    drive_bit(~bad_stop[0], bclk);
    if (s2) drive_bit(~bad_stop[1], bclk);
    drive_bit(1'b1, 2 * bclk);
  endtask

  task automatic check_frame(input string name, input logic [7:0] ed, input logic ep,
                             input logic ef);
    int waited;
    frm_t f;
    waited = 0;
    while (got.size() == 0 && waited < 400) begin
      @(negedge clk);
      waited++;
    end
    if (got.size() == 0) begin
      n_cmp++;
      n_err++;
      $display("FAIL %s_timeout: got no frame, expected data 0x%0h", name, ed);
    end else begin
      f = got.pop_front();
      check({name, "_data"}, 32'(f.d), 32'(ed));
      check({name, "_perr"}, 32'(f.p), 32'(ep));
      check({name, "_ferr"}, 32'(f.f), 32'(ef));
      check({name, "_extra"}, 32'(got.size()), 32'd0);
    end
  endtask

  vec_t tbl[9];

  initial begin
    int ovr0;
    frm_t e;
    logic [7:0] d;
    logic [3:0] len;
    logic pe, pt, s2, bp;
    logic [1:0] bs;
    int div, r;

    tbl[0] = '{8'hA5, 4'd8,  1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 8'hA5, 1'b0, 1'b0};
    tbl[1] = '{8'h5A, 4'd8,  1'b1, 1'b1, 1'b0, 1'b1, 2'b00, 8'h5A, 1'b1, 1'b0};
    tbl[2] = '{8'h3C, 4'd8,  1'b0, 1'b0, 1'b0, 1'b0, 2'b01, 8'h3C, 1'b0, 1'b1};
    tbl[3] = '{8'h11, 4'd8,  1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 8'h11, 1'b0, 1'b0};
    tbl[4] = '{8'hFF, 4'd5,  1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 8'h1F, 1'b0, 1'b0};
    tbl[5] = '{8'hB6, 4'd7,  1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 8'h36, 1'b0, 1'b0};
    tbl[6] = '{8'h2A, 4'd6,  1'b0, 1'b0, 1'b1, 1'b0, 2'b10, 8'h2A, 1'b0, 1'b1};
    tbl[7] = '{8'hC3, 4'd3,  1'b1, 1'b1, 1'b0, 1'b0, 2'b00, 8'hC3, 1'b0, 1'b0};
    tbl[8] = '{8'h6E, 4'd15, 1'b1, 1'b0, 1'b1, 1'b1, 2'b00, 8'h6E, 1'b1, 1'b0};

    // Reset state.
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_outputs", {19'd0, rx_valid, rx_data, parity_err, frame_err, overrun, busy}, 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (4) @(posedge clk);
    #1;

    // Directed table.
    for (int i = 0; i < 9; i++) begin
      send_frame(tbl[i].data, tbl[i].len, tbl[i].pe, tbl[i].pt, tbl[i].s2, tbl[i].bad_par,
                 tbl[i].bad_stop, 3);
      check_frame($sformatf("vec%0d", i), tbl[i].exp_data, tbl[i].exp_perr, tbl[i].exp_ferr);
    end

    // Start glitch: 16 clk low then high.
    ovr0 = ovr_cnt;
    rx = 1'b0;
    repeat (8) @(posedge clk);
    #1;
    check("glitch_busy_high", 32'(busy), 32'd1);
    repeat (8) @(posedge clk);
    #1;
    rx = 1'b1;
    repeat (100) @(posedge clk);
    #1;
    check("glitch_busy_low", 32'(busy), 32'd0);
    check("glitch_no_frame", 32'(got.size()), 32'd0);
    check("glitch_no_overrun", 32'(ovr_cnt - ovr0), 32'd0);

    // Overrun: second frame dropped while the first is unaccepted.
    rx_ready = 1'b0;
    ovr0 = ovr_cnt;
    send_frame(8'h01, 4'd8, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 3);
    check("ovr_valid1", 32'(rx_valid), 32'd1);
    check("ovr_data1", 32'(rx_data), 32'h01);
    send_frame(8'h02, 4'd8, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 3);
    check("ovr_data_held", 32'(rx_data), 32'h01);
    check("ovr_pulses", 32'(ovr_cnt - ovr0), 32'd1);
    rx_ready = 1'b1;
    @(posedge clk);
    #1;
    check("ovr_valid_falls", 32'(rx_valid), 32'd0);
    check_frame("ovr_accept", 8'h01, 1'b0, 1'b0);

    // 5 bits, two stop bits; then reset in the middle of the next frame.
    send_frame(8'h13, 4'd5, 1'b0, 1'b0, 1'b1, 1'b0, 2'b00, 3);
    check_frame("len5_s2", 8'h13, 1'b0, 1'b0);
    check("len5_data_held", 32'(rx_data), 32'h13);
    length = 4'd5;
    stop2 = 1'b1;
    drive_bit(1'b0, 64);
    drive_bit(1'b1, 64);
    drive_bit(1'b0, 30);
    check("midframe_busy", 32'(busy), 32'd1);
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    rx = 1'b1;
    @(negedge clk);
    check("post_rst_outputs", {19'd0, rx_valid, rx_data, parity_err, frame_err, overrun, busy},
          32'd0);
    repeat (128) @(posedge clk);
    #1;
    check("post_rst_no_frame", 32'(got.size()), 32'd0);
    send_frame(8'h07, 4'd5, 1'b0, 1'b0, 1'b1, 1'b0, 2'b00, 3);
    check_frame("post_rst_frame", 8'h07, 1'b0, 1'b0);

    // Randomized frames against the reference model.
    for (int i = 0; i < 25; i++) begin
      div = $urandom_range(1, 3);
      r = $urandom_range(0, 9);
      len = (r < 8) ? 4'(5 + r % 4) : ((r == 8) ? 4'd0 : 4'd12);
      d = 8'($urandom);
      pe = 1'($urandom);
      pt = 1'($urandom);
      s2 = 1'($urandom);
      bp = pe && ($urandom_range(0, 4) == 0);
      bs[0] = ($urandom_range(0, 5) == 0);
      bs[1] = s2 && ($urandom_range(0, 5) == 0);
      e = ref_frame(d, len, pe, s2, bp, bs);
      send_frame(d, len, pe, pt, s2, bp, bs, div);
      check_frame($sformatf("rand%0d", i), e.d, e.p, e.f);
    end

    check("total_overruns", 32'(ovr_cnt), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
